// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: operation encodings, FSM states
// and the helpers that classify an operation by access size and direction.
package lsu_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_SB  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_RDW,
        ST_WR
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    function automatic size_t op_size(op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic op_is_store(op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_signed(op_t op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic is_misaligned(op_t op, logic [1:0] offset);
        case (op_size(op))
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request side (MEM stage) and data-memory side of the load/store unit.
// The master modport is the requester plus memory; the slave modport is the unit.
interface load_store_unit_if import lsu_pkg::*; #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                   req;
    op_t                    op;
    logic [ADDR_WIDTH-1:0]  address;
    logic [DATA_WIDTH-1:0]  store_data;
    logic                   ready;
    logic                   done;
    logic                   misaligned;
    logic [DATA_WIDTH-1:0]  load_data;
    logic                   mem_read;
    logic                   mem_write;
    logic [ADDR_WIDTH-1:0]  read_address;
    logic [ADDR_WIDTH-1:0]  write_address;
    logic [DATA_WIDTH-1:0]  write_data;
    logic [DATA_WIDTH-1:0]  read_data;

    modport master (
        output req, op, address, store_data, read_data,
        input  ready, done, misaligned, load_data,
               mem_read, mem_write, read_address, write_address, write_data
    );

    modport slave (
        input  req, op, address, store_data, read_data,
        output ready, done, misaligned, load_data,
               mem_read, mem_write, read_address, write_address, write_data
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts/extends a load from a memory word and
// merges a store operand into the word for read-modify-write.
module lsu_byte_lane import lsu_pkg::*; (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            offset,
    input  size_t                 size,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] store_operand,
    output logic [DATA_WIDTH-1:0] load_value,
    output logic [DATA_WIDTH-1:0] merged_word
);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = word[{offset, 3'b000} +: 8];
    assign sel_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_value = word;
        case (size)
            SZ_BYTE: load_value = {{24{is_signed & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_value = {{16{is_signed & sel_half[15]}}, sel_half};
            default: load_value = word;
        endcase
    end

    // A halfword store feeds operand bytes 0/1 into lanes 0/1 or 2/3.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic       lane_hit;
        logic [7:0] lane_src;

        assign lane_hit = (size == SZ_WORD)
                       || ((size == SZ_HALF) && (offset[1] == LANE[1]))
                       || ((size == SZ_BYTE) && (offset == LANE));
        assign lane_src = (size == SZ_BYTE) ? store_operand[7:0]
                        : (size == SZ_HALF) ? store_operand[8*(gi%2) +: 8]
                        : store_operand[8*gi +: 8];
        assign merged_word[8*gi +: 8] = lane_hit ? lane_src : word[8*gi +: 8];
    end
endmodule

// File: rtl/load_store_unit.sv
// Sequencer between the MEM stage and word-organised data memory: one request
// at a time, read-modify-write for sub-word stores, extended sub-word loads.
module load_store_unit import lsu_pkg::*; #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    state_t                 state_reg, state_next;
    op_t                    op_reg, op_next;
    logic [1:0]             offset_reg, offset_next;
    logic [DATA_WIDTH-1:0]  store_data_reg, store_data_next;
    logic [DATA_WIDTH-1:0]  load_data_reg, load_data_next;
    logic [DATA_WIDTH-1:0]  write_data_reg, write_data_next;
    logic [ADDR_WIDTH-1:0]  read_address_reg, read_address_next;
    logic [ADDR_WIDTH-1:0]  write_address_reg, write_address_next;
    logic                   done_reg, done_next;
    logic                   misaligned_reg, misaligned_next;

    logic [ADDR_WIDTH-1:0]  aligned_address;
    logic [DATA_WIDTH-1:0]  lane_load_value;
    logic [DATA_WIDTH-1:0]  lane_merged_word;
    size_t                  lane_size;
    logic                   lane_signed;

    assign aligned_address = {bus.address[ADDR_WIDTH-1:2], 2'b00};
    assign lane_size       = op_size(op_reg);
    assign lane_signed     = op_is_signed(op_reg);

    lsu_byte_lane u_byte_lane (
        .word          (bus.read_data),
        .offset        (offset_reg),
        .size          (lane_size),
        .is_signed     (lane_signed),
        .store_operand (store_data_reg),
        .load_value    (lane_load_value),
        .merged_word   (lane_merged_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            op_reg            <= OP_LB;
            offset_reg        <= '0;
            store_data_reg    <= '0;
            load_data_reg     <= '0;
            write_data_reg    <= '0;
            read_address_reg  <= '0;
            write_address_reg <= '0;
            done_reg          <= 1'b0;
            misaligned_reg    <= 1'b0;
        end else begin
            state_reg         <= state_next;
            op_reg            <= op_next;
            offset_reg        <= offset_next;
            store_data_reg    <= store_data_next;
            load_data_reg     <= load_data_next;
            write_data_reg    <= write_data_next;
            read_address_reg  <= read_address_next;
            write_address_reg <= write_address_next;
            done_reg          <= done_next;
            misaligned_reg    <= misaligned_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        op_next            = op_reg;
        offset_next        = offset_reg;
        store_data_next    = store_data_reg;
        load_data_next     = load_data_reg;
        write_data_next    = write_data_reg;
        read_address_next  = read_address_reg;
        write_address_next = write_address_reg;
        done_next          = 1'b0;
        misaligned_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req) begin
                    op_next         = bus.op;
                    offset_next     = bus.address[1:0];
                    store_data_next = bus.store_data;
                    if (is_misaligned(bus.op, bus.address[1:0])) begin
                        done_next       = 1'b1;
                        misaligned_next = 1'b1;
                    end else if (bus.op == OP_SW) begin
                        write_data_next    = bus.store_data;
                        write_address_next = aligned_address;
                        state_next         = ST_WR;
                    end else begin
                        read_address_next = aligned_address;
                        if (op_is_store(bus.op))
                            write_address_next = aligned_address;
                        state_next = ST_RD;
                    end
                end
            end
            ST_RD: state_next = ST_RDW;
            ST_RDW: begin
                if (op_is_store(op_reg)) begin
                    write_data_next = lane_merged_word;
                    state_next      = ST_WR;
                end else begin
                    load_data_next = lane_load_value;
                    done_next      = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            ST_WR: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Strobes come straight from state so an asynchronous reset kills them at once.
    assign bus.ready         = (state_reg == ST_IDLE);
    assign bus.mem_read      = (state_reg == ST_RD);
    assign bus.mem_write     = (state_reg == ST_WR);
    assign bus.done          = done_reg;
    assign bus.misaligned    = misaligned_reg;
    assign bus.load_data     = load_data_reg;
    assign bus.write_data    = write_data_reg;
    assign bus.read_address  = read_address_reg;
    assign bus.write_address = write_address_reg;
endmodule
